// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out handshake bundle.
// The master side supplies parallel words and watches the serial stream;
// the slave side is the serializer itself.
interface piso_serializer_if #(
  parameter int NBITS = 8
);

  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_msg;
  logic             out_q;
  logic             out_val;
  logic             out_last;

  modport master (
    output in_val,
    output in_msg,
    input  in_rdy,
    input  out_q,
    input  out_val,
    input  out_last
  );

  modport slave (
    input  in_val,
    input  in_msg,
    output in_rdy,
    output out_q,
    output out_val,
    output out_last
  );

endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: captures an NBITS-wide word on a valid/ready transfer and
// emits it LSB first, one bit per clock, with out_val/out_last framing.
// A new word can be accepted on the final bit of a frame, so back-to-back
// words stream without a gap cycle.
// Optional feature: define PISO_SERIALIZER_PARITY_EN to append one even-parity
// bit (XOR of the captured word) after the data bits; out_last and the ready
// window then move to that parity bit.
module piso_serializer #(
  parameter int NBITS = 8
) (
  input logic              clk,
  input logic              reset,
  piso_serializer_if.slave bus
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FLEN = NBITS + 1;
`else
  localparam int FLEN = NBITS;
`endif

  localparam int CW = (FLEN > 1) ? $clog2(FLEN) : 1;
  localparam logic [CW-1:0] LAST_IDX   = CW'(FLEN - 1);
  localparam logic [CW-1:0] PENULT_IDX = CW'(FLEN - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [NBITS-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             xfer;
  logic             at_last;
  logic             at_penult;

`ifdef PISO_SERIALIZER_PARITY_EN
  logic             parity;
`endif

  // in_rdy is a register, so the transfer decision never loops in_val back to in_rdy
  assign xfer      = bus.in_val && bus.in_rdy;
  assign at_last   = (cnt == LAST_IDX);
  assign at_penult = (cnt == PENULT_IDX);

  // Frame sequencer: load on transfer, walk the bit counter through the frame, fall back to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sreg         <= '0;
      cnt          <= '0;
      bus.out_q    <= 1'b0;
      bus.out_val  <= 1'b0;
      bus.out_last <= 1'b0;
      bus.in_rdy   <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity       <= 1'b0;
`endif
    end else if (xfer) begin
      // bit 0 goes out immediately; the rest wait in sreg already shifted down
      state        <= SHIFT;
      sreg         <= bus.in_msg >> 1;
      cnt          <= '0;
      bus.out_q    <= bus.in_msg[0];
      bus.out_val  <= 1'b1;
      bus.out_last <= 1'b0;
      bus.in_rdy   <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity       <= ^bus.in_msg;
`endif
    end else if (state == SHIFT && !at_last) begin
      cnt          <= cnt + CW'(1);
      bus.out_val  <= 1'b1;
      bus.out_last <= at_penult;
      bus.in_rdy   <= at_penult;
      sreg         <= sreg >> 1;
`ifdef PISO_SERIALIZER_PARITY_EN
      bus.out_q    <= at_penult ? parity : sreg[0];
`else
      bus.out_q    <= sreg[0];
`endif
    end else begin
      state        <= IDLE;
      sreg         <= '0;
      cnt          <= '0;
      bus.out_q    <= 1'b0;
      bus.out_val  <= 1'b0;
      bus.out_last <= 1'b0;
      bus.in_rdy   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed and random stimulus for piso_serializer,
// checked every cycle against a queue-based reference model of the frame
// stream (pending frame bits queued per accepted word).
// Honors PISO_SERIALIZER_PARITY_EN the same way as the design.
module tb_piso_serializer;

  localparam int NBITS = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FLEN = NBITS + 1;
`else
  localparam int FLEN = NBITS;
`endif

  logic clk;
  logic reset;

  piso_serializer_if #(.NBITS(NBITS)) bus ();

  piso_serializer #(.NBITS(NBITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int assert_count = 0;
  int fail_count   = 0;

  bit exp_q[$];
  bit model_rst = 1'b1;
  bit acc;
  int val_cycles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // queue the bits a word should produce on the serial line
  task automatic push_frame(input logic [NBITS-1:0] msg);
    for (int i = 0; i < NBITS; i++) exp_q.push_back(msg[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
    exp_q.push_back(^msg);
`endif
  endtask

  task automatic check(input string tag, input logic obs, input logic exp_v);
    assert_count++;
    assert (obs === exp_v) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic record_timeout(input string tag);
    assert_count++;
    fail_count++;
    $error("[TB] FAIL %s: observed timeout expected completion", tag);
  endtask

  task automatic check_output();
    logic e_val, e_q, e_last, e_rdy;
    e_val  = (exp_q.size() > 0);
    e_q    = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
    e_last = (exp_q.size() == 1);
    e_rdy  = !model_rst && (exp_q.size() <= 1);
    check("out_val",  bus.out_val,  e_val);
    check("out_q",    bus.out_q,    e_q);
    check("out_last", bus.out_last, e_last);
    check("in_rdy",   bus.in_rdy,   e_rdy);
  endtask

  // one clock: advance the model across the rising edge, then compare on the falling edge
  task automatic apply_stimulus(output bit accepted);
    bit               can;
    logic             v;
    logic             r;
    logic [NBITS-1:0] m;
    can = !model_rst && (exp_q.size() <= 1);
    v   = bus.in_val;
    r   = reset;
    m   = bus.in_msg;
    @(posedge clk);
    accepted = 1'b0;
    if (r) begin
      exp_q.delete();
      model_rst = 1'b1;
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (v && can) begin
        accepted = 1'b1;
        push_frame(m);
      end
      model_rst = 1'b0;
    end
    @(negedge clk);
    if (bus.out_val === 1'b1) val_cycles++;
    check_output();
  endtask

  task automatic send_word(input logic [NBITS-1:0] msg);
    bit a;
    bit done;
    done = 1'b0;
    bus.in_val = 1'b1;
    bus.in_msg = msg;
    for (int i = 0; i < 40 && !done; i++) begin
      apply_stimulus(a);
      if (a) done = 1'b1;
    end
    if (!done) record_timeout("accept_wait");
  endtask

  task automatic drain();
    bit a;
    bus.in_val = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) apply_stimulus(a);
    if (exp_q.size() > 0) record_timeout("drain_wait");
    apply_stimulus(a);
  endtask

  initial begin
    reset      = 1'b1;
    bus.in_val = 1'b1;
    bus.in_msg = 8'hFF;

    // reset held three cycles with a valid word offered
    for (int i = 0; i < 3; i++) apply_stimulus(acc);
    reset      = 1'b0;
    bus.in_val = 1'b0;
    apply_stimulus(acc);
    apply_stimulus(acc);

    // single word, counting framed cycles
    val_cycles = 0;
    send_word(8'hB4);
    drain();
    check("b4_frame_len", (val_cycles == FLEN), 1'b1);

    // back-to-back with in_val held
    val_cycles = 0;
    send_word(8'h01);
    send_word(8'h80);
    drain();
    check("b2b_frame_len", (val_cycles == 2 * FLEN), 1'b1);

    // in_msg changes mid-frame must not disturb the frame in flight
    send_word(8'h0F);
    send_word(8'h55);
    drain();

    // reset after three bits of a frame
    send_word(8'hFF);
    bus.in_val = 1'b0;
    apply_stimulus(acc);
    apply_stimulus(acc);
    reset = 1'b1;
    apply_stimulus(acc);
    reset = 1'b0;
    apply_stimulus(acc);
    send_word(8'h03);
    drain();

    // parity-relevant words
    send_word(8'h07);
    drain();
    send_word(8'h03);
    drain();

    // reset asserted together with a valid word: the word is dropped
    bus.in_val = 1'b1;
    bus.in_msg = 8'hA5;
    reset      = 1'b1;
    apply_stimulus(acc);
    reset      = 1'b0;
    bus.in_val = 1'b0;
    apply_stimulus(acc);
    apply_stimulus(acc);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 59) == 0);
      bus.in_val = $urandom_range(0, 1);
      bus.in_msg = NBITS'($urandom);
      apply_stimulus(acc);
    end
    reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
